piece_dispenser: RTL
====================

Name: piece_dispenser

Overview:
- Consumer end of the random-bag interface.
- Issues `newbag` requests to the bag generator and captures each 21-bit, 7-piece bag when `bag_ready` is seen.
- Hands pieces to the game controller one at a time on a `next` pulse, with a one-piece preview.
- Double-buffers bags (current + next) so dispensing never stalls at a bag boundary once both buffers are primed.

Parameters:
- NSLOTS, 7, pieces per bag.
- PW, 3, bits per piece code; bag width = NSLOTS*PW.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- newbag  out  1  bag request to generator, level, held until captured
- bag_ready  in  1  generator done flag
- bag_pieces  in  NSLOTS*PW  bag contents; slot i at [PW*i+PW-1:PW*i], slot 0 dispensed first
- next  in  1  single-cycle request: advance to following piece
- piece_valid  out  1  piece holds a valid piece
- piece  out  PW  current piece code
- preview_valid  out  1  preview holds a valid piece
- preview  out  PW  piece that follows piece
- bad_code  out  1  sticky: a captured slot held code 7

Behaviour:
- Reset (async, active-high):
  - cur_valid=0, nxt_valid=0, idx=0, req state IDLE, bad_code=0.
  - All outputs are 0.
- Piece codes: 0..6 legal. A captured slot value 7 is stored as 0 and sets bad_code, which stays set until reset.
- Request FSM (registered, newbag = state==REQ):
  - IDLE -> REQ when !(cur_valid && nxt_valid).
  - REQ -> WAITLOW on an edge with bag_ready=1; bag_pieces is captured on that same edge.
  - WAITLOW -> IDLE when bag_ready=0. This blocks capture of a stale bag while ready is still high.
  - reset mid-REQ: newbag drops immediately (async); the FSM restarts from IDLE.
- Capture destination:
  - To cur if cur_valid=0 after this cycle's next handling; then idx=0.
  - Otherwise to nxt, and nxt_valid=1.
- Dispense rules:
  - piece = cur slot[idx]; piece_valid = cur_valid.
  - next with piece_valid=0 is ignored; no state change, no error.
  - next with idx<6: idx++.
  - next with idx==6:
    - nxt_valid=1: cur<=nxt, idx=0, nxt_valid=0.
    - nxt_valid=0 with capture the same edge: captured bag goes straight to cur, idx=0.
    - Otherwise cur_valid=0.
- Preview:
  - idx<6: preview = cur slot[idx+1], preview_valid = cur_valid.
  - idx==6: preview = nxt slot0, preview_valid = nxt_valid.
  - Otherwise preview=0, preview_valid=0.
- Latency:
  - Capture edge -> piece_valid high on the following cycle (outputs are registered state decoded combinationally).
  - next edge -> new piece visible on the next cycle.
- Throughput: at most one piece per cycle. Back-to-back next pulses are legal.

Decomposition:
- tetris_pkg holds:
  - piece_t (3-bit typedef) and enum constants PIECE_I..PIECE_Z = 0..6.
  - NSLOTS.
  - The req-FSM state enum {IDLE, REQ, WAITLOW}.
- One natural sub-module: bag_req_fsm.
  - Ports: clk, reset, space, bag_ready, newbag, capture.
  - Keeps the handshake separable for reuse and verification.
- Slot select and preview mux remain in the top module.

Test Plan:
- Reset, then a generator model returns 21'o6543210 three cycles after newbag rises, holding ready until newbag is low:
  - newbag rises the cycle after reset release and falls after capture.
  - Next cycle: piece=0, preview=1, piece_valid=1.
  - Second request issued and second bag 21'o0123456 captured into nxt.
- With both bags loaded, 7 next pulses back to back:
  - Pieces 0,1,2,3,4,5,6.
  - At idx=6 preview=6 (nxt slot0).
  - 8th piece=6 with no bubble.
  - newbag re-asserts after the swap.
- Generator withholds ready; 7 next pulses:
  - piece_valid=0, preview_valid=0 after the 7th.
  - Extra next ignored.
  - Ready arriving on the same edge as the 7th next loads cur directly, with idx=0.
- Ready held high after capture:
  - No second capture until ready drops for ≥1 cycle (WAITLOW).
  - nxt contents unchanged.
- Bag 21'o7777777:
  - All pieces read 0.
  - bad_code=1 and remains 1 after subsequent legal bags; clears only on reset.
- Assert reset while in REQ with idx=3:
  - All outputs 0 immediately.
  - Full request sequence restarts after release.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the piece dispenser slice.
//   - piece_t / PIECE_* : 3-bit piece codes, 0..6 legal, 7 is a corrupt code
//   - bag_t             : one 7-slot bag, slot 0 in the least significant bits
//   - req_state_t       : states of the bag request handshake
//   - sanitize_bag / bag_has_bad : scrub corrupt codes out of a captured bag
package tetris_pkg;

  localparam int NSLOTS = 7;
  localparam int PW     = 3;

  typedef logic [PW-1:0] piece_t;

  localparam piece_t PIECE_I   = 3'd0;
  localparam piece_t PIECE_J   = 3'd1;
  localparam piece_t PIECE_L   = 3'd2;
  localparam piece_t PIECE_O   = 3'd3;
  localparam piece_t PIECE_S   = 3'd4;
  localparam piece_t PIECE_T   = 3'd5;
  localparam piece_t PIECE_Z   = 3'd6;
  localparam piece_t PIECE_BAD = 3'd7;

  // Index of the last slot in a bag.
  localparam logic [2:0] LAST_IDX = 3'd6;

  typedef piece_t [NSLOTS-1:0] bag_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAITLOW = 2'd2
  } req_state_t;

  // Replace every corrupt slot code with PIECE_I so downstream never sees 7.
  function automatic bag_t sanitize_bag(input bag_t bag);
    bag_t clean;
    for (int i = 0; i < NSLOTS; i++) begin
      if (bag[i] == PIECE_BAD) begin
        clean[i] = PIECE_I;
      end else begin
        clean[i] = bag[i];
      end
    end
    return clean;
  endfunction

  // True when any slot of the bag carries the corrupt code.
  function automatic logic bag_has_bad(input bag_t bag);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (bag[i] == PIECE_BAD) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

endpackage

// File: rtl/bag_req_fsm.sv
// Request/handshake state machine towards the bag generator.
// Ports:
//   clk, reset (async, active-high)
//   space     : at least one bag buffer is free
//   bag_ready : generator done flag
//   newbag    : request level, high exactly while in REQ
//   capture   : strobe, the bag on the bus is taken on this clock edge
module bag_req_fsm
  import tetris_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic space,
  input  logic bag_ready,
  output logic newbag,
  output logic capture
);

  req_state_t state_r;
  req_state_t state_s;
  logic       capture_s;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and capture decode. WAITLOW keeps a ready flag that is still
  // high from the previous bag from being taken as a fresh bag.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (space) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (bag_ready) begin
          state_s   = WAITLOW;
          capture_s = 1'b1;
        end else begin
          state_s = REQ;
        end
      end
      WAITLOW: begin
        if (!bag_ready) begin
          state_s = IDLE;
        end else begin
          state_s = WAITLOW;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign newbag  = (state_r == REQ);
  assign capture = capture_s;

endmodule

// File: rtl/piece_dispenser.sv
// Consumer end of the random-bag interface. Requests bags, double-buffers
// them (cur + nxt) and hands out one piece per next pulse with a one-piece
// preview that looks across the bag boundary.
// Ports:
//   clk, reset (async, active-high)
//   newbag / bag_ready / bag_pieces : handshake and data from the generator
//   next                            : advance to the following piece
//   piece_valid / piece             : current piece
//   preview_valid / preview         : piece after the current one
//   bad_code                        : sticky, a captured slot held code 7
module piece_dispenser
  import tetris_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  output logic                 newbag,
  input  logic                 bag_ready,
  input  logic [NSLOTS*PW-1:0] bag_pieces,
  input  logic                 next,
  output logic                 piece_valid,
  output logic [PW-1:0]        piece,
  output logic                 preview_valid,
  output logic [PW-1:0]        preview,
  output logic                 bad_code
);

  bag_t       cur_r;
  bag_t       nxt_r;
  logic       cur_valid_r;
  logic       nxt_valid_r;
  logic [2:0] idx_r;
  logic       bad_code_r;
  piece_t     piece_r;
  logic       piece_valid_r;
  piece_t     preview_r;
  logic       preview_valid_r;

  bag_t       cur_s;
  bag_t       nxt_s;
  logic       cur_valid_s;
  logic       nxt_valid_s;
  logic [2:0] idx_s;
  piece_t     piece_s;
  piece_t     preview_s;
  logic       preview_valid_s;

  bag_t       bag_in_s;
  bag_t       bag_clean_s;
  logic       space_s;
  logic       capture_s;
  logic       adv_s;
  logic       wrap_s;
  logic       swap_s;
  logic       drain_s;
  logic       to_cur_s;
  logic       to_nxt_s;

  assign space_s     = !(cur_valid_r && nxt_valid_r);
  assign bag_in_s    = bag_t'(bag_pieces);
  assign bag_clean_s = sanitize_bag(bag_in_s);

  bag_req_fsm u_req (
    .clk       (clk),
    .reset     (reset),
    .space     (space_s),
    .bag_ready (bag_ready),
    .newbag    (newbag),
    .capture   (capture_s)
  );

  // A next with no valid piece is dropped. A wrap either swaps nxt in or,
  // with nothing buffered, empties cur; an empty cur (including one emptied
  // on this very edge) is where a captured bag lands.
  assign adv_s    = next && cur_valid_r;
  assign wrap_s   = adv_s && (idx_r == LAST_IDX);
  assign swap_s   = wrap_s && nxt_valid_r;
  assign drain_s  = wrap_s && !nxt_valid_r;
  assign to_cur_s = capture_s && (!cur_valid_r || drain_s);
  assign to_nxt_s = capture_s && !(!cur_valid_r || drain_s);

  // Next buffer state.
  always_comb begin
    cur_s       = cur_r;
    cur_valid_s = cur_valid_r;
    nxt_s       = nxt_r;
    nxt_valid_s = nxt_valid_r;
    idx_s       = idx_r;

    if (to_cur_s) begin
      cur_s       = bag_clean_s;
      cur_valid_s = 1'b1;
      idx_s       = 3'd0;
    end else if (swap_s) begin
      cur_s       = nxt_r;
      cur_valid_s = 1'b1;
      idx_s       = 3'd0;
    end else if (drain_s) begin
      cur_valid_s = 1'b0;
    end else if (adv_s) begin
      idx_s = idx_r + 3'd1;
    end else begin
      idx_s = idx_r;
    end

    if (to_nxt_s) begin
      nxt_s       = bag_clean_s;
      nxt_valid_s = 1'b1;
    end else if (swap_s) begin
      nxt_valid_s = 1'b0;
    end else begin
      nxt_valid_s = nxt_valid_r;
    end
  end

  // Output decode from the next buffer state so the registered outputs line
  // up with the buffers on the same cycle.
  always_comb begin
    piece_s         = cur_s[idx_s];
    preview_s       = 3'd0;
    preview_valid_s = 1'b0;
    if (idx_s < LAST_IDX) begin
      preview_s       = cur_s[idx_s + 3'd1];
      preview_valid_s = cur_valid_s;
    end else if (idx_s == LAST_IDX) begin
      preview_s       = nxt_s[3'd0];
      preview_valid_s = nxt_valid_s;
    end else begin
      preview_s       = 3'd0;
      preview_valid_s = 1'b0;
    end
  end

  // Buffers, index, sticky error flag and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_r           <= '0;
      nxt_r           <= '0;
      cur_valid_r     <= 1'b0;
      nxt_valid_r     <= 1'b0;
      idx_r           <= 3'd0;
      bad_code_r      <= 1'b0;
      piece_r         <= 3'd0;
      piece_valid_r   <= 1'b0;
      preview_r       <= 3'd0;
      preview_valid_r <= 1'b0;
    end else begin
      cur_r           <= cur_s;
      nxt_r           <= nxt_s;
      cur_valid_r     <= cur_valid_s;
      nxt_valid_r     <= nxt_valid_s;
      idx_r           <= idx_s;
      bad_code_r      <= bad_code_r | (capture_s & bag_has_bad(bag_in_s));
      piece_r         <= piece_s;
      piece_valid_r   <= cur_valid_s;
      preview_r       <= preview_s;
      preview_valid_r <= preview_valid_s;
    end
  end

  assign piece         = piece_r;
  assign piece_valid   = piece_valid_r;
  assign preview       = preview_r;
  assign preview_valid = preview_valid_r;
  assign bad_code      = bad_code_r;

endmodule
